// File: rtl/vga_stream_source.sv
// vga_stream_source
// -----------------------------------------------------------------------------
// VGA raster generator used as a video source for the filter chain. Counters
// sweep the full raster; visible pixels are taken either from an upstream
// pixel memory (fixed one-cycle latency request port) or from a built-in test
// pattern. Sync, blank and colour leave through a two-stage pipeline so they
// stay mutually aligned, two cycles behind the counters.
//
// Ports:
//   VGA_CLK       pixel clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   pattern_sel   0 external, 1 colour bars, 2 gradient, 3 checkerboard
//   pixel_req     high while the counters address a visible pixel
//   pixel_x/y     coordinates of the requested pixel
//   pixel_data    {R,G,B}, valid one cycle after the matching pixel_req
//   frame_start   one-cycle pulse with the counters at (0,0)
//   frame_count   completed frames since reset (wraps)
//   oVGA_*        VGA outputs (HS/VS active low, SYNC_N tied low)
// -----------------------------------------------------------------------------
module vga_stream_source #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 48,
    parameter int H_BP   = 88,
    parameter int V_FP   = 13,
    parameter int V_SYNC = 3,
    parameter int V_BP   = 32
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic [1:0]  pattern_sel,
    output logic        pixel_req,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    input  logic [23:0] pixel_data,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N
);

    localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS        = 10'(WIDTH);
    localparam logic [9:0] H_SYNC_START = 10'(WIDTH + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(WIDTH + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(HEIGHT);
    localparam logic [9:0] V_SYNC_START = 10'(HEIGHT + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(HEIGHT + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] BAR_LAST     = 10'(WIDTH / 8 - 1);

    // Colour of bar idx, left (white) to right (black).
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // (x+y)[8:1] folded into 8 bits: halves summed plus the carry of the LSBs.
    function automatic logic [7:0] grad_blue(input logic [8:0] x, input logic [8:0] y);
        return x[8:1] + y[8:1] + {7'd0, x[0] & y[0]};
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [1:0]  active_sel_q, active_sel_d;
    logic [9:0]  bar_pix_q, bar_pix_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    logic        visible_s, hs_n_s, vs_n_s, frame_start_s, h_wrap_s;

    logic        s1_vis_q, s1_vis_d;
    logic        s1_hs_n_q, s1_hs_n_d;
    logic        s1_vs_n_q, s1_vs_n_d;
    logic [8:0]  s1_x_q, s1_x_d;
    logic [8:0]  s1_y_q, s1_y_d;
    logic [2:0]  s1_bar_q, s1_bar_d;

    logic [23:0] colour_s;
    logic [23:0] out_rgb_q, out_rgb_d;
    logic        out_hs_q, out_hs_d;
    logic        out_vs_q, out_vs_d;
    logic        out_blank_q, out_blank_d;

    // Stage 0: raster decode straight from the counters.
    always_comb begin
        h_wrap_s      = (h_cnt_q == H_LAST);
        visible_s     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_n_s        = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
        vs_n_s        = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
        frame_start_s = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0) && !reset;
    end

    // Next state of the raster counters, bar tracker and pattern latch.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        bar_pix_d     = bar_pix_q;
        bar_idx_d     = bar_idx_q;
        if (h_wrap_s) begin
            h_cnt_d   = 10'd0;
            bar_pix_d = 10'd0;
            bar_idx_d = 3'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d       = 10'd0;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            // Bar index steps every WIDTH/8 columns without a divider.
            if (bar_pix_q == BAR_LAST) begin
                bar_pix_d = 10'd0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 10'd1;
            end
        end
        // Pattern only changes at the frame boundary.
        if (frame_start_s) begin
            active_sel_d = pattern_sel;
        end else begin
            active_sel_d = active_sel_q;
        end
    end

    // Stage 1 capture of the decoded raster position.
    always_comb begin
        s1_vis_d  = visible_s;
        s1_hs_n_d = hs_n_s;
        s1_vs_n_d = vs_n_s;
        s1_x_d    = h_cnt_q[8:0];
        s1_y_d    = v_cnt_q[8:0];
        s1_bar_d  = bar_idx_q;
    end

    // Stage 2: pattern colour for the stage-1 pixel, source mux and blanking.
    always_comb begin
        colour_s = 24'h000000;
        case (active_sel_q)
            2'd1:    colour_s = bar_colour(s1_bar_q);
            2'd2:    colour_s = {s1_x_q[7:0], s1_y_q[7:0], grad_blue(s1_x_q, s1_y_q)};
            2'd3:    colour_s = (s1_x_q[5] ^ s1_y_q[5]) ? 24'hFFFFFF : 24'h000000;
            default: colour_s = pixel_data;
        endcase
        if (s1_vis_q) begin
            out_rgb_d = colour_s;
        end else begin
            out_rgb_d = 24'h000000;
        end
        out_hs_d    = s1_hs_n_q;
        out_vs_d    = s1_vs_n_q;
        out_blank_d = s1_vis_q;
    end

    // All state registers; reset leaves syncs inactive and the screen blank.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            frame_count_q <= 16'd0;
            active_sel_q  <= 2'd0;
            bar_pix_q     <= 10'd0;
            bar_idx_q     <= 3'd0;
            s1_vis_q      <= 1'b0;
            s1_hs_n_q     <= 1'b1;
            s1_vs_n_q     <= 1'b1;
            s1_x_q        <= 9'd0;
            s1_y_q        <= 9'd0;
            s1_bar_q      <= 3'd0;
            out_rgb_q     <= 24'h000000;
            out_hs_q      <= 1'b1;
            out_vs_q      <= 1'b1;
            out_blank_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            active_sel_q  <= active_sel_d;
            bar_pix_q     <= bar_pix_d;
            bar_idx_q     <= bar_idx_d;
            s1_vis_q      <= s1_vis_d;
            s1_hs_n_q     <= s1_hs_n_d;
            s1_vs_n_q     <= s1_vs_n_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_bar_q      <= s1_bar_d;
            out_rgb_q     <= out_rgb_d;
            out_hs_q      <= out_hs_d;
            out_vs_q      <= out_vs_d;
            out_blank_q   <= out_blank_d;
        end
    end

    assign pixel_req    = visible_s;
    assign pixel_x      = h_cnt_q;
    assign pixel_y      = v_cnt_q[8:0];
    assign frame_start  = frame_start_s;
    assign frame_count  = frame_count_q;
    assign oVGA_R       = out_rgb_q[23:16];
    assign oVGA_G       = out_rgb_q[15:8];
    assign oVGA_B       = out_rgb_q[7:0];
    assign oVGA_HS      = out_hs_q;
    assign oVGA_VS      = out_vs_q;
    assign oVGA_SYNC_N  = 1'b0;
    assign oVGA_BLANK_N = out_blank_q;

endmodule

// File: tb/tb_vga_stream_source.sv
// Testbench for vga_stream_source on a reduced raster (80 x 48 total).
// A reference model walks the raster by plain arithmetic on a cycle position,
// pushes the expected output pixel into a queue, and an independent monitor
// pops and compares two cycles later. Stage-0 outputs are checked in place.
module tb_vga_stream_source;

    localparam int W = 64, H = 40;
    localparam int HFP = 4, HSY = 6, HBP = 6;
    localparam int VFP = 2, VSY = 3, VBP = 3;
    localparam int HT = W + HFP + HSY + HBP;
    localparam int VT = H + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        sync_n;
        logic [23:0] rgb;
    } px_t;

    localparam px_t RESET_PX = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, sync_n: 1'b0, rgb: 24'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pattern_sel;
    logic        pixel_req;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [23:0] pixel_data;
    logic        frame_start;
    logic [15:0] frame_count;
    logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N;

    vga_stream_source #(
        .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .VGA_CLK(clk), .reset(reset), .pattern_sel(pattern_sel),
        .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_data(pixel_data), .frame_start(frame_start), .frame_count(frame_count),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS),
        .oVGA_SYNC_N(oVGA_SYNC_N), .oVGA_BLANK_N(oVGA_BLANK_N)
    );

    always #5 clk = ~clk;

    px_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  started = 1'b0;
    int  pos = 0;

    // Expected output pixel for raster position (x,y) with pattern sel.
    function automatic px_t expect_px(input int x, input int y, input int sel);
        px_t e;
        bit  vis;
        vis       = (x < W) && (y < H);
        e.hs      = !((x >= W + HFP) && (x < W + HFP + HSY));
        e.vs      = !((y >= H + VFP) && (y < H + VFP + VSY));
        e.blank_n = vis;
        e.sync_n  = 1'b0;
        if (!vis)          e.rgb = 24'h0;
        else if (sel == 0) e.rgb = {8'(x), 8'(y), 8'hA5};
        else if (sel == 1) e.rgb = BARS[x / (W / 8)];
        else if (sel == 2) e.rgb = {8'(x), 8'(y), 8'((x + y) / 2)};
        else               e.rgb = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
        return e;
    endfunction

    // Upstream pixel memory: answers a request one cycle later, FFFFFF otherwise.
    initial begin
        logic       r;
        logic [9:0] xx;
        logic [8:0] yy;
        pixel_data = 24'hFFFFFF;
        forever begin
            @(negedge clk);
            r  = pixel_req;
            xx = pixel_x;
            yy = pixel_y;
            @(posedge clk);
            #1;
            pixel_data = r ? {xx[7:0], yy[7:0], 8'hA5} : 24'hFFFFFF;
        end
    end

    // Reference model: per cycle, check stage-0 outputs and queue the pixel due 2 cycles later.
    initial begin
        px_t  pending, e;
        bit   have_pending;
        bit   prev_rst;
        int   sel_now, x, y;
        bit   vis, ok;
        logic [15:0] fc_e;
        have_pending = 1'b0;
        prev_rst     = 1'b1;
        sel_now      = 0;
        wait (started);
        forever begin
            @(negedge clk);
            if (reset) begin
                e       = RESET_PX;
                pos     = 0;
                sel_now = 0;
                n_cmp++;
                ok = (frame_start === 1'b0) && (!prev_rst || frame_count === 16'd0);
                if (!ok) begin
                    n_err++;
                    $display("FAIL reset_state t=%0t: frame_start=%b frame_count=%0d, required frame_start=0 frame_count=0",
                             $time, frame_start, frame_count);
                end
            end else begin
                x = pos % HT;
                y = (pos / HT) % VT;
                if (x == 0 && y == 0) sel_now = int'(pattern_sel);
                e    = expect_px(x, y, sel_now);
                vis  = (x < W) && (y < H);
                fc_e = 16'(pos / FRAME);
                n_cmp++;
                ok = (frame_start === (x == 0 && y == 0)) && (pixel_req === vis) &&
                     (frame_count === fc_e) &&
                     (!vis || (pixel_x === 10'(x) && pixel_y === 9'(y)));
                if (!ok) begin
                    n_err++;
                    $display("FAIL stage0 t=%0t: fs=%b req=%b x=%0d y=%0d fc=%0d, required fs=%b req=%b x=%0d y=%0d fc=%0d",
                             $time, frame_start, pixel_req, pixel_x, pixel_y, frame_count,
                             (x == 0 && y == 0), vis, x, y, fc_e);
                end
                pos++;
            end
            // A reset now clears the pipeline before the previous pixel can leave it.
            if (have_pending) begin
                if (reset) pending = RESET_PX;
                exp_q.push_back(pending);
            end
            pending      = e;
            have_pending = 1'b1;
            prev_rst     = reset;
        end
    end

    // Monitor: every cycle the DUT presents one raster sample; compare against the queue.
    initial begin
        px_t e, a;
        wait (started);
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                a = '{hs: oVGA_HS, vs: oVGA_VS, blank_n: oVGA_BLANK_N, sync_n: oVGA_SYNC_N,
                      rgb: {oVGA_R, oVGA_G, oVGA_B}};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL raster t=%0t: hs=%b vs=%b blank_n=%b sync_n=%b rgb=%h, required hs=%b vs=%b blank_n=%b sync_n=%b rgb=%h",
                             $time, a.hs, a.vs, a.blank_n, a.sync_n, a.rgb,
                             e.hs, e.vs, e.blank_n, e.sync_n, e.rgb);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until the counters of the current cycle sit at (x,y).
    task automatic wait_xy(input int x, input int y);
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME + 4 && !found; i++) begin
            @(posedge clk);
            #1;
            if ((pos % HT) == x && ((pos / HT) % VT) == y) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_xy: position (%0d,%0d) not reached, required within %0d cycles", x, y, FRAME + 4);
        end
    endtask

    // Stimulus: directed sequence from the test plan, then random pattern changes and resets.
    initial begin
        reset       = 1'b1;
        pattern_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        run(1);
        reset = 1'b0;
        run(FRAME + 100);
        pattern_sel = 2'd1;
        run(FRAME);
        pattern_sel = 2'd2;
        wait_xy(0, 0);
        wait_xy(0, 20);
        pattern_sel = 2'd3;
        run(FRAME + HT);
        wait_xy(40, 30);
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(FRAME);
        for (int i = 0; i < 12; i++) begin
            run($urandom_range(300, 3000));
            if ($urandom_range(0, 2) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 4));
                reset = 1'b0;
            end else begin
                pattern_sel = 2'($urandom_range(0, 3));
            end
        end
        run(FRAME + 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
